// File: rtl/lvds_tx_flit_arbiter.sv
// lvds_tx_flit_arbiter
// Packet-atomic round-robin arbiter sharing one 32-bit LVDS transmit flit
// port between NREQ requesters. A grant is held for a whole packet (header
// bits [27:24] give the payload length), a one-entry output register
// decouples link backpressure from requester acceptance, and a watchdog
// aborts a body that stalls for TIMEOUT cycles.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   req               per-requester "has a flit" level
//   req_put           per-requester flit data, requester i at [32i+31:32i]
//   EN_req_put        per-requester enqueue strobe (legal while RDY_req_put)
//   RDY_req_put       arbiter can accept from requester i this cycle
//   link_put          flit presented to the serializer
//   EN_link_put       serializer enqueue strobe
//   RDY_link_put      serializer can accept a flit
//   grant             one-hot current owner, zero in IDLE
//   busy              arbiter is not IDLE
//   timeout_err       sticky watchdog-abort flag, cleared by clr_err
//   clr_err           synchronous clear of timeout_err (abort wins)
//   flit_count        flits delivered to the link, wraps at 16 bits
module lvds_tx_flit_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        req,
  input  logic [32*NREQ-1:0]     req_put,
  input  logic [NREQ-1:0]        EN_req_put,
  output logic [NREQ-1:0]        RDY_req_put,
  output logic [31:0]            link_put,
  output logic                   EN_link_put,
  input  logic                   RDY_link_put,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clr_err,
  output logic [15:0]            flit_count
);

  localparam int unsigned FW = 32;
  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 4;
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  logic [1:0]    r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last;
  logic [LW-1:0] r_rem;
  logic [CW-1:0] r_wdog;
  logic          r_out_valid;
  logic [FW-1:0] r_out_data;
  logic          r_timeout_err;
  logic [CW-1:0] r_flit_count;

  logic [1:0]    w_state_nxt;
  logic [OW-1:0] w_owner_nxt;
  logic [OW-1:0] w_last_nxt;
  logic [LW-1:0] w_rem_nxt;
  logic [CW-1:0] w_wdog_nxt;
  logic          w_out_valid_nxt;
  logic [FW-1:0] w_out_data_nxt;
  logic          w_timeout_err_nxt;
  logic [CW-1:0] w_flit_count_nxt;

  logic          w_busy;
  logic          w_space;
  logic          w_link_en;
  logic          w_accept;
  logic          w_abort;
  logic [FW-1:0] w_flit;
  logic          w_en_own;
  logic          w_req_own;
  logic [OW-1:0] w_pick;
  logic          w_pick_vld;
  int unsigned   w_dist;
  int unsigned   w_best;

  // Output register can take a flit when empty or draining this cycle
  assign w_busy    = (r_state != S_IDLE);
  assign w_link_en = r_out_valid & RDY_link_put;
  assign w_space   = !r_out_valid | w_link_en;
  assign w_accept  = w_busy & w_en_own & w_space;

  // Owner-side view of the requester inputs
  always_comb begin
    w_flit    = '0;
    w_en_own  = 1'b0;
    w_req_own = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_flit    = req_put[FW*i +: FW];
        w_en_own  = EN_req_put[i];
        w_req_own = req[i];
      end
    end
  end

  // Round-robin pick: requester with the smallest distance above r_last wins
  always_comb begin
    w_pick     = r_last;
    w_pick_vld = |req;
    w_best     = NREQ;
    w_dist     = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      // (j - (last+1)) mod NREQ, kept non-negative
      w_dist = (j + 2 * NREQ - 1 - 32'(r_last)) % NREQ;
      if (req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = OW'(j);
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last;
    w_rem_nxt         = r_rem;
    w_wdog_nxt        = '0;
    w_out_valid_nxt   = r_out_valid;
    w_out_data_nxt    = r_out_data;
    w_timeout_err_nxt = r_timeout_err;
    w_flit_count_nxt  = r_flit_count + {{(CW-1){1'b0}}, w_link_en};
    w_abort           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nxt = w_pick;
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_accept) begin
          w_rem_nxt = w_flit[27:24];
          if (w_flit[27:24] == '0) begin
            w_last_nxt  = r_owner;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BODY;
          end
        end else if (!w_req_own) begin
          // Owner withdrew before sending a header; no packet, last unchanged
          w_state_nxt = S_IDLE;
        end
      end
      S_BODY: begin
        if (w_accept) begin
          w_rem_nxt = r_rem - LW'(1);
          if (r_rem == LW'(1)) begin
            w_last_nxt  = r_owner;
            w_state_nxt = S_IDLE;
          end
        end else if (r_wdog == WDOG_LAST) begin
          w_abort     = 1'b1;
          w_last_nxt  = r_owner;
          w_state_nxt = S_IDLE;
        end else if (w_space) begin
          // Only count cycles where the requester, not the link, is stalling
          w_wdog_nxt = r_wdog + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_accept) begin
      w_out_data_nxt  = w_flit;
      w_out_valid_nxt = 1'b1;
    end else if (w_link_en) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_abort) begin
      w_timeout_err_nxt = 1'b1;
    end else if (clr_err) begin
      w_timeout_err_nxt = 1'b0;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_owner       <= '0;
      r_last        <= OW'(NREQ - 1);
      r_rem         <= '0;
      r_wdog        <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_timeout_err <= 1'b0;
      r_flit_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_rem         <= w_rem_nxt;
      r_wdog        <= w_wdog_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_data    <= w_out_data_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_flit_count  <= w_flit_count_nxt;
    end
  end

  // Requester-facing strobes derived from the registered owner
  always_comb begin
    grant       = '0;
    RDY_req_put = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i]       = w_busy && (r_owner == OW'(i));
      RDY_req_put[i] = w_busy && (r_owner == OW'(i)) && w_space;
    end
  end

  assign link_put    = r_out_data;
  assign EN_link_put = w_link_en;
  assign busy        = w_busy;
  assign timeout_err = r_timeout_err;
  assign flit_count  = r_flit_count;

endmodule
